// File: rtl/rx_ctrl_pkg.sv
// Shared constants for the RX CPU controller: register map, FSM encoding,
// STATUS/CTRL bit positions and the default DATA-read wait bound.
package rx_ctrl_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_ACK     = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  localparam int STS_NEMPTY   = 0;
  localparam int STS_FULL     = 1;
  localparam int STS_FIFO     = 2;
  localparam int STS_UNDERRUN = 3;
  localparam int STS_IRQ      = 4;

  localparam int CTRL_IRQ_EN      = 0;
  localparam int CTRL_IRQ_ON_FULL = 1;

  localparam int DEF_TIMEOUT_W = 16;
  localparam int DEF_TIMEOUT   = 1000;

endpackage

// File: rtl/rx_wait_timer.sv
// Wait counter for starved DATA reads: clear has priority over enable,
// terminal-count flag is high while the count equals TIMEOUT-1.
module rx_wait_timer #(
  parameter int TIMEOUT_W = 16,
  parameter int TIMEOUT   = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [TIMEOUT_W-1:0] TC_VAL = TIMEOUT_W'(TIMEOUT - 1);

  logic [TIMEOUT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/rx_cpu_ctrl.sv
// CPU-side controller for the RX staging buffer: decodes DATA/STATUS/CTRL accesses,
// stalls DATA reads until data is staged (bounded), pops the buffer and raises a level irq.
module rx_cpu_ctrl
  import rx_ctrl_pkg::*;
#(
  parameter int TIMEOUT_W = DEF_TIMEOUT_W,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_req,
  input  logic        bus_rnw,
  input  logic [1:0]  bus_addr,
  input  logic        bus_uds,
  input  logic        bus_lds,
  input  logic [15:0] bus_wdata,
  output logic [15:0] bus_rdata,
  output logic        bus_ack,
  input  logic [15:0] buf_q,
  input  logic        buf_empty,
  input  logic        buf_full,
  input  logic        fifo_has_data,
  output logic        buf_rd_byte,
  output logic        buf_rd_word,
  output logic        irq
);

  state_t      r_state;
  state_t      w_next;

  logic [15:0] r_rdata;
  logic        r_ack;
  logic        r_rd_byte;
  logic        r_rd_word;
  logic        r_irq;
  logic [1:0]  r_ctrl;
  logic        r_underrun;
  logic        r_sts_rd;

  logic        w_word;
  logic        w_any;
  logic        w_data_rd;
  logic        w_avail;
  logic [15:0] w_data_val;
  logic [15:0] w_status;
  logic [15:0] w_reg_rdata;
  logic [15:0] w_rdata_nxt;
  logic        w_pop_word;
  logic        w_pop_byte;
  logic        w_ctrl_we;
  logic        w_sts_rd;
  logic        w_set_ur;
  logic        w_clr_ur;
  logic        w_tc;
  logic        w_unused_wdata;

  assign w_unused_wdata = ^bus_wdata[15:2];

  assign w_word     = bus_uds & bus_lds;
  assign w_any      = bus_uds | bus_lds;
  assign w_data_rd  = bus_rnw && (bus_addr == ADDR_DATA) && w_any;
  assign w_avail    = w_word ? buf_full : !buf_empty;
  // A byte read always takes the upper byte, mirrored onto both lanes.
  assign w_data_val = w_word ? buf_q : {buf_q[15:8], buf_q[15:8]};

  always_comb begin
    w_status               = '0;
    w_status[STS_NEMPTY]   = !buf_empty;
    w_status[STS_FULL]     = buf_full;
    w_status[STS_FIFO]     = fifo_has_data;
    w_status[STS_UNDERRUN] = r_underrun;
    w_status[STS_IRQ]      = r_irq;
  end

  always_comb begin
    w_reg_rdata = '0;
    unique case (bus_addr)
      ADDR_STATUS: w_reg_rdata = w_status;
      ADDR_CTRL:   w_reg_rdata = {14'd0, r_ctrl};
      default:     w_reg_rdata = '0;
    endcase
  end

  always_comb begin
    w_next      = r_state;
    w_rdata_nxt = '0;
    w_pop_word  = 1'b0;
    w_pop_byte  = 1'b0;
    w_ctrl_we   = 1'b0;
    w_sts_rd    = 1'b0;
    w_set_ur    = 1'b0;
    w_clr_ur    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus_req) begin
          if (w_data_rd) begin
            if (w_avail) begin
              w_next      = S_ACK;
              w_rdata_nxt = w_data_val;
              w_pop_word  = w_word;
              w_pop_byte  = !w_word;
            end else begin
              w_next = S_WAIT;
            end
          end else begin
            w_next = S_ACK;
            if (bus_rnw && w_any) w_rdata_nxt = w_reg_rdata;
            w_ctrl_we = !bus_rnw && (bus_addr == ADDR_CTRL) && bus_lds;
            w_sts_rd  = bus_rnw && (bus_addr == ADDR_STATUS) && w_any;
          end
        end
      end
      S_WAIT: begin
        if (w_avail) begin
          w_next      = S_ACK;
          w_rdata_nxt = w_data_val;
          w_pop_word  = w_word;
          w_pop_byte  = !w_word;
        end else if (w_tc) begin
          w_next   = S_ACK;
          w_set_ur = 1'b1;
        end
      end
      S_ACK: begin
        w_next   = S_RELEASE;
        w_clr_ur = r_sts_rd;
      end
      S_RELEASE: begin
        if (!bus_req) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_rdata    <= '0;
      r_ack      <= 1'b0;
      r_rd_byte  <= 1'b0;
      r_rd_word  <= 1'b0;
      r_irq      <= 1'b0;
      r_ctrl     <= '0;
      r_underrun <= 1'b0;
      r_sts_rd   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_ack     <= (w_next == S_ACK);
      r_rd_word <= w_pop_word;
      r_rd_byte <= w_pop_byte;
      if (w_next == S_ACK) begin
        r_rdata  <= w_rdata_nxt;
        r_sts_rd <= w_sts_rd;
      end
      if (w_ctrl_we) r_ctrl <= bus_wdata[1:0];
      if (w_set_ur) begin
        r_underrun <= 1'b1;
      end else if (w_clr_ur) begin
        r_underrun <= 1'b0;
      end
      r_irq <= r_ctrl[CTRL_IRQ_EN] &
               (r_ctrl[CTRL_IRQ_ON_FULL] ? buf_full : (!buf_empty | r_underrun));
    end
  end

  // Counter is zeroed on every edge that does not stay in (or enter) WAIT.
  rx_wait_timer #(
    .TIMEOUT_W (TIMEOUT_W),
    .TIMEOUT   (TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_next != S_WAIT),
    .i_en  (r_state == S_WAIT),
    .o_tc  (w_tc)
  );

  assign bus_rdata   = r_rdata;
  assign bus_ack     = r_ack;
  assign buf_rd_byte = r_rd_byte;
  assign buf_rd_word = r_rd_word;
  assign irq         = r_irq;

endmodule

// File: tb/tb_rx_cpu_ctrl.sv
// Scoreboard bench for rx_cpu_ctrl: instance A uses the default wait bound,
// instance B uses TIMEOUT=8 for the underrun path; both share buffer/bus inputs.
module tb_rx_cpu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_a, req_b;
  logic        bus_rnw;
  logic [1:0]  bus_addr;
  logic        bus_uds, bus_lds;
  logic [15:0] bus_wdata;
  logic [15:0] buf_q;
  logic        buf_empty, buf_full, fifo_has_data;

  logic [15:0] rdata_a, rdata_b;
  logic        ack_a, ack_b, rdb_a, rdb_b, rdw_a, rdw_b, irq_a, irq_b;

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    int          inst;
    int          cyc;
    logic [15:0] rdata;
    logic        pw;
    logic        pb;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rx_cpu_ctrl u_dut_a (
    .clk(clk), .reset(reset), .bus_req(req_a), .bus_rnw(bus_rnw), .bus_addr(bus_addr),
    .bus_uds(bus_uds), .bus_lds(bus_lds), .bus_wdata(bus_wdata), .bus_rdata(rdata_a),
    .bus_ack(ack_a), .buf_q(buf_q), .buf_empty(buf_empty), .buf_full(buf_full),
    .fifo_has_data(fifo_has_data), .buf_rd_byte(rdb_a), .buf_rd_word(rdw_a), .irq(irq_a)
  );

  rx_cpu_ctrl #(.TIMEOUT_W(16), .TIMEOUT(8)) u_dut_b (
    .clk(clk), .reset(reset), .bus_req(req_b), .bus_rnw(bus_rnw), .bus_addr(bus_addr),
    .bus_uds(bus_uds), .bus_lds(bus_lds), .bus_wdata(bus_wdata), .bus_rdata(rdata_b),
    .bus_ack(ack_b), .buf_q(buf_q), .buf_empty(buf_empty), .buf_full(buf_full),
    .fifo_has_data(fifo_has_data), .buf_rd_byte(rdb_b), .buf_rd_word(rdw_b), .irq(irq_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail(input string name);
    n_total++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic ack_of(input int inst);
    return (inst == 0) ? ack_a : ack_b;
  endfunction

  // Monitor: every ack pops one expectation; pops outside ack are protocol errors.
  always @(negedge clk) begin
    exp_t e;
    if (ack_a === 1'b1 || ack_b === 1'b1) begin
      if (sb.size() == 0) begin
        fail("unexpected_ack");
      end else begin
        e = sb.pop_front();
        chk("ack_inst", (ack_b === 1'b1) ? 1 : 0, e.inst);
        chk("ack_cycle", cyc, e.cyc);
        if (ack_b === 1'b1) begin
          chk("rdata", rdata_b, e.rdata);
          chk("rd_word", rdw_b, e.pw);
          chk("rd_byte", rdb_b, e.pb);
        end else begin
          chk("rdata", rdata_a, e.rdata);
          chk("rd_word", rdw_a, e.pw);
          chk("rd_byte", rdb_a, e.pb);
        end
      end
    end
    if (((rdw_a | rdb_a) & ~ack_a) === 1'b1) fail("pop_without_ack_a");
    if (((rdw_b | rdb_b) & ~ack_b) === 1'b1) fail("pop_without_ack_b");
    if ((rdw_a & rdb_a) === 1'b1 || (rdw_b & rdb_b) === 1'b1) fail("double_pop");
  end

  task automatic bus_access(input int inst, input logic rnw, input logic [1:0] addr,
                            input logic uds, input logic lds, input logic [15:0] wdata,
                            input logic [15:0] erd, input logic epw, input logic epb,
                            input int lat, input int hold);
    exp_t e;
    int n;
    @(posedge clk); #1;
    e.inst = inst; e.cyc = cyc + lat; e.rdata = erd; e.pw = epw; e.pb = epb;
    sb.push_back(e);
    bus_rnw = rnw; bus_addr = addr; bus_uds = uds; bus_lds = lds; bus_wdata = wdata;
    if (inst == 0) req_a = 1'b1; else req_b = 1'b1;
    n = 0;
    while (ack_of(inst) !== 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) fail("ack_wait_expired");
    repeat (hold) @(posedge clk);
    #1;
    req_a = 1'b0; req_b = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit (cycle %0d)", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    reset = 1'b1; req_a = 1'b0; req_b = 1'b0; bus_rnw = 1'b0; bus_addr = 2'd0;
    bus_uds = 1'b0; bus_lds = 1'b0; bus_wdata = 16'h0; buf_q = 16'h0;
    buf_empty = 1'b1; buf_full = 1'b0; fifo_has_data = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", ack_a, 0);
    chk("rst_rdata", rdata_a, 0);
    chk("rst_rd_word", rdw_a, 0);
    chk("rst_rd_byte", rdb_a, 0);
    chk("rst_irq", irq_a, 0);
    chk("rst_ack_b", ack_b, 0);
    reset = 1'b0;

    // Word read with full buffer; req held 8 extra cycles must give one ack.
    buf_q = 16'hA53C; buf_empty = 1'b0; buf_full = 1'b1;
    bus_access(0, 1, 2'd0, 1, 1, 16'h0, 16'hA53C, 1, 0, 1, 8);

    // Byte reads of upper byte via either lane; no-strobe read is a no-op.
    buf_q = 16'h7E00; buf_empty = 1'b0; buf_full = 1'b0;
    bus_access(0, 1, 2'd0, 1, 0, 16'h0, 16'h7E7E, 0, 1, 1, 0);
    bus_access(0, 1, 2'd0, 0, 1, 16'h0, 16'h7E7E, 0, 1, 1, 0);
    bus_access(0, 1, 2'd0, 0, 0, 16'h0, 16'h0000, 0, 0, 1, 0);

    // Starved word read: upper byte lands at +20, full at +21, ack at +22.
    buf_q = 16'h0; buf_empty = 1'b1; buf_full = 1'b0;
    fork
      bus_access(0, 1, 2'd0, 1, 1, 16'h0, 16'hBEEF, 1, 0, 22, 0);
      begin
        @(posedge clk);
        repeat (20) @(posedge clk);
        #1; buf_q = 16'hBEEF; buf_empty = 1'b0;
        @(posedge clk);
        #1; buf_full = 1'b1;
      end
    join

    // Timeout on instance B (TIMEOUT=8): 8 WAIT cycles, then underrun, sticky until read.
    buf_q = 16'h1111; buf_empty = 1'b1; buf_full = 1'b0; fifo_has_data = 1'b1;
    bus_access(1, 1, 2'd0, 1, 0, 16'h0, 16'h0000, 0, 0, 9, 0);
    bus_access(1, 1, 2'd1, 1, 1, 16'h0, 16'h000C, 0, 0, 1, 0);
    bus_access(1, 1, 2'd1, 1, 1, 16'h0, 16'h0004, 0, 0, 1, 0);
    bus_access(0, 1, 2'd1, 1, 1, 16'h0, 16'h0004, 0, 0, 1, 0);

    // Interrupt enable / irq_on_full.
    bus_access(0, 0, 2'd2, 0, 1, 16'h0001, 16'h0000, 0, 0, 1, 0);
    #1; chk("irq_empty", irq_a, 0);
    @(posedge clk); #1;
    buf_q = 16'h5500; buf_empty = 1'b0;
    chk("irq_lag", irq_a, 0);
    @(posedge clk); #1;
    chk("irq_nonempty", irq_a, 1);
    bus_access(0, 0, 2'd2, 1, 1, 16'h0003, 16'h0000, 0, 0, 1, 0);
    #1; chk("irq_on_full_partial", irq_a, 0);
    buf_full = 1'b1;
    @(posedge clk); #1;
    chk("irq_on_full_full", irq_a, 1);
    bus_access(0, 1, 2'd2, 1, 1, 16'h0, 16'h0003, 0, 0, 1, 0);
    bus_access(0, 0, 2'd2, 1, 0, 16'hFFFF, 16'h0000, 0, 0, 1, 0);
    bus_access(0, 1, 2'd2, 0, 1, 16'h0, 16'h0003, 0, 0, 1, 0);
    bus_access(0, 1, 2'd1, 1, 1, 16'h0, 16'h0017, 0, 0, 1, 0);
    bus_access(0, 1, 2'd3, 1, 1, 16'h0, 16'h0000, 0, 0, 1, 0);
    bus_access(0, 0, 2'd3, 1, 1, 16'h1234, 16'h0000, 0, 0, 1, 0);

    // Reset during WAIT: access abandoned, nothing acked or popped.
    buf_empty = 1'b1; buf_full = 1'b0;
    @(posedge clk); #1;
    bus_rnw = 1'b1; bus_addr = 2'd0; bus_uds = 1'b1; bus_lds = 1'b1; req_a = 1'b1;
    repeat (5) @(posedge clk);
    #1; reset = 1'b1;
    repeat (2) @(posedge clk);
    #1; req_a = 1'b0; reset = 1'b0;
    chk("wait_rst_ack", ack_a, 0);
    chk("wait_rst_irq", irq_a, 0);
    buf_q = 16'hCAFE; buf_full = 1'b1; buf_empty = 1'b0;
    repeat (20) @(posedge clk);
    bus_access(0, 1, 2'd0, 1, 1, 16'h0, 16'hCAFE, 1, 0, 1, 0);

    // Reset during ACK: the already-visible ack counts, nothing after it.
    buf_q = 16'h1234;
    begin
      exp_t e;
      @(posedge clk); #1;
      e.inst = 0; e.cyc = cyc + 1; e.rdata = 16'h1234; e.pw = 1'b1; e.pb = 1'b0;
      sb.push_back(e);
      bus_rnw = 1'b1; bus_addr = 2'd0; bus_uds = 1'b1; bus_lds = 1'b1; req_a = 1'b1;
      @(posedge clk); #1;
      reset = 1'b1; req_a = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("ack_rst_ack", ack_a, 0);
      chk("ack_rst_rd_word", rdw_a, 0);
      chk("ack_rst_rdata", rdata_a, 0);
    end
    repeat (20) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
